uart_wb_fifo_ctrl: RTL
======================

// Module: uart_wb_fifo_ctrl
// PURPOSE
//  Wishbone register front-end for the UART, parametrised successor of the single-byte controller.
//  Holds RX and TX FIFOs, sticky error flags, interrupt enables/threshold, and a baud-divisor register.
//  Sits between the Wishbone slave decode and the UART RX/TX serial cores. Drives a single level IRQ.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  register window base; offsets below are relative to it
//  DATA_W      8              character width, 5..9; upper bits of read data are zero
//  FIFO_DEPTH  16             entries per FIFO, power of two, >=2
//  BAUD_RST    16'd434        reset value of BAUD_DIV
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous reset, active-high
//  i_wb_valid    in   1       Wishbone cycle/strobe
//  i_wb_adr      in   32      byte address
//  i_wb_we       in   1       1=write
//  i_wb_dat      in   32      write data
//  i_wb_sel      in   4       byte lanes (honoured for CTRL and BAUD_DIV only)
//  o_wb_ack      out  1       one-cycle acknowledge
//  o_wb_dat      out  32      read data, valid with o_wb_ack
//  i_rx_data     in   DATA_W  received character
//  i_rx_valid    in   1       one-cycle strobe: i_rx_data/i_frame_err/i_parity_err valid
//  i_frame_err   in   1       frame error for current character
//  i_parity_err  in   1       parity error for current character
//  o_tx_data     out  DATA_W  TX FIFO head (first-word fall-through)
//  o_tx_valid    out  1       TX FIFO non-empty
//  i_tx_ready    in   1       TX core accepts head when o_tx_valid & i_tx_ready
//  o_baud_div    out  16      BAUD_DIV register
//  o_irq         out  1       registered interrupt, level
// BEHAVIOUR
//  Map: +0x00 RX_DATA(RO,pop) +0x04 TX_DATA(WO,push) +0x08 STAT(RO) +0x0C ERR(W1C) +0x10 CTRL(RW) +0x14 BAUD_DIV(RW)
//  STAT: [0]rx_empty [1]rx_full [2]tx_empty [3]tx_full [4]err_any [15:8]rx_count [23:16]tx_count.
//  ERR: [0]frame [1]parity [2]rx_overrun [3]tx_overflow; sticky; write-1-clears; set wins over clear same cycle.
//  CTRL: [0]ie_rx_thr [1]ie_tx_empty [2]ie_err [3]rx_flush(self-clr) [4]tx_flush(self-clr) [15:8]rx_thr.
//  Ack: o_wb_ack=1 the cycle after i_wb_valid & !o_wb_ack; never two consecutive acks; side effects
//   (pop/push/W1C/CTRL write) occur exactly once, on the cycle ack is raised. Unmapped address: ack, read 0, no effect.
//  Read data registered with ack. RX_DATA read returns head and pops; on empty returns 0, no pop, no error.
//  TX_DATA write: push i_wb_dat[DATA_W-1:0]; if full, drop and set tx_overflow.
//  RX push on i_rx_valid: frame or parity error -> discard char, set matching flag; else if full
//   -> drop, set rx_overrun; else push. Simultaneous push+pop on either FIFO: both happen, count unchanged.
//  Push on full in same cycle as pop: pop first, push accepted (no overrun).
//  Flush bits: FIFO emptied next cycle; a same-cycle push is discarded.
//  o_irq (registered) = ie_rx_thr&(rx_count>=rx_thr & rx_thr!=0) | ie_tx_empty&tx_empty | ie_err&err_any.
//  Counts are $clog2(FIFO_DEPTH)+1 bits, zero-extended into STAT; pointers wrap modulo FIFO_DEPTH.
//  Reset (any time, incl. mid-transaction): FIFOs empty, ERR=0, CTRL=0, BAUD_DIV=BAUD_RST,
//   o_wb_ack=0, o_wb_dat=0, o_irq=0, o_tx_valid=0, o_tx_data=0; pending Wishbone cycle gets no ack.
// STRUCTURE
//  Package uart_ctrl_pkg: register offsets, STAT/ERR/CTRL bit indices, BAUD_RST default.
//  Sub-module uart_sync_fifo (DATA_W, DEPTH; push/pop/flush, FWFT head, count, full, empty),
//   instantiated twice (RX, TX). Register decode, ERR/CTRL/BAUD logic, IRQ in top.
// TESTING
//  Reset; read STAT -> 0x0000_0005; read BAUD_DIV -> 434; o_irq=0, o_tx_valid=0.
//  Write 0x41,0x42 to TX_DATA, i_tx_ready=0 -> tx_count=2, o_tx_data=0x41; ready 1 cycle -> head 0x42.
//  17 i_rx_valid chars (DEPTH 16) -> rx_full=1, ERR=0x4; read RX_DATA x16 returns chars 1..16 in order.
//  i_rx_valid with i_frame_err -> char not stored, ERR[0]=1; write ERR=0x1 -> ERR=0; set+W1C same cycle -> stays 1.
//  CTRL rx_thr=3, ie_rx_thr=1: 2 chars -> o_irq=0; 3rd char -> o_irq=1 next cycle; read one -> o_irq=0.
//  Hold i_wb_valid 4 cycles on RX_DATA -> acks on alternate cycles, exactly one pop per ack; assert rst mid-cycle -> no ack.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl_pkg
//  Description : Register map, bit positions and defaults shared by the UART
//                Wishbone FIFO controller and its FIFO sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [31:0] C_OFF_RX_DATA = 32'h0000_0000;
    localparam logic [31:0] C_OFF_TX_DATA = 32'h0000_0004;
    localparam logic [31:0] C_OFF_STAT    = 32'h0000_0008;
    localparam logic [31:0] C_OFF_ERR     = 32'h0000_000C;
    localparam logic [31:0] C_OFF_CTRL    = 32'h0000_0010;
    localparam logic [31:0] C_OFF_BAUD    = 32'h0000_0014;

    // STAT bit positions
    localparam int C_STAT_RX_EMPTY = 0;
    localparam int C_STAT_RX_FULL  = 1;
    localparam int C_STAT_TX_EMPTY = 2;
    localparam int C_STAT_TX_FULL  = 3;
    localparam int C_STAT_ERR_ANY  = 4;

    // ERR bit positions
    localparam int C_ERR_FRAME     = 0;
    localparam int C_ERR_PARITY    = 1;
    localparam int C_ERR_RX_OVR    = 2;
    localparam int C_ERR_TX_OVF    = 3;

    // CTRL bit positions
    localparam int C_CTRL_IE_RX_THR   = 0;
    localparam int C_CTRL_IE_TX_EMPTY = 1;
    localparam int C_CTRL_IE_ERR      = 2;
    localparam int C_CTRL_RX_FLUSH    = 3;
    localparam int C_CTRL_TX_FLUSH    = 4;

    localparam logic [15:0] C_BAUD_RST_DEFAULT = 16'd434;

    typedef enum logic [2:0] {
        REG_RX_DATA = 3'd0,
        REG_TX_DATA = 3'd1,
        REG_STAT    = 3'd2,
        REG_ERR     = 3'd3,
        REG_CTRL    = 3'd4,
        REG_BAUD    = 3'd5,
        REG_NONE    = 3'd6
    } reg_sel_e;

    // Map a window-relative byte offset to a register; anything else is unmapped
    function automatic reg_sel_e decode_reg(input logic [31:0] off);
        reg_sel_e sel;
        case (off)
            C_OFF_RX_DATA: sel = REG_RX_DATA;
            C_OFF_TX_DATA: sel = REG_TX_DATA;
            C_OFF_STAT:    sel = REG_STAT;
            C_OFF_ERR:     sel = REG_ERR;
            C_OFF_CTRL:    sel = REG_CTRL;
            C_OFF_BAUD:    sel = REG_BAUD;
            default:       sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Synchronous first-word-fall-through FIFO with flush. A push
//                on a full FIFO is accepted only when a pop happens in the
//                same cycle; otherwise it is dropped and o_drop pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_data,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_drop
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == CW'(DEPTH));
    assign o_count   = count_q;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;
    assign o_drop    = i_push & ~i_flush & ~w_do_push;
    // Head is forced to zero when empty so stale storage never leaks out
    assign o_data    = o_empty ? '0 : r_mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush overrides any push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[wr_ptr_q] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_wb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_wb_fifo_ctrl
//  Description : Wishbone register front-end for the UART: RX/TX FIFOs,
//                sticky error flags, interrupt control and baud divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_wb_fifo_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BAUD_RST   = C_BAUD_RST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_valid,
    input  logic [31:0]       i_wb_adr,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    output logic              o_wb_ack,
    output logic [31:0]       o_wb_dat,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_frame_err,
    input  logic              i_parity_err,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [15:0]       o_baud_div,
    output logic              o_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        ack_q;
    logic [31:0] dat_q,  dat_d;
    logic [3:0]  err_q,  err_d;
    logic [2:0]  ie_q,   ie_d;
    logic [7:0]  thr_q,  thr_d;
    logic [15:0] baud_q, baud_d;
    logic        irq_q,  irq_d;

    logic [31:0] w_off;
    reg_sel_e    w_sel;
    logic        w_req, w_wr, w_rd;
    logic        w_ctrl_lo, w_ctrl_hi;
    logic [3:0]  w_err_clr, w_err_set;

    logic [DATA_W-1:0] w_rx_head, w_tx_head;
    logic [CW-1:0]     w_rx_count, w_tx_count;
    logic              w_rx_full, w_rx_empty, w_rx_drop;
    logic              w_tx_full, w_tx_empty, w_tx_drop;
    logic              w_rx_push, w_rx_pop, w_rx_flush;
    logic              w_tx_push, w_tx_pop, w_tx_flush;
    logic [7:0]        w_rx_cnt8, w_tx_cnt8;

    // A new request is only taken when no ack is outstanding, so acks never abut
    assign w_off     = i_wb_adr - BASE_ADDR;
    assign w_sel     = decode_reg(w_off);
    assign w_req     = i_wb_valid & ~ack_q;
    assign w_wr      = w_req & i_wb_we;
    assign w_rd      = w_req & ~i_wb_we;

    assign w_ctrl_lo = w_wr & (w_sel == REG_CTRL) & i_wb_sel[0];
    assign w_ctrl_hi = w_wr & (w_sel == REG_CTRL) & i_wb_sel[1];

    assign w_rx_push  = i_rx_valid & ~i_frame_err & ~i_parity_err;
    assign w_rx_pop   = w_rd & (w_sel == REG_RX_DATA);
    assign w_rx_flush = w_ctrl_lo & i_wb_dat[C_CTRL_RX_FLUSH];
    assign w_tx_push  = w_wr & (w_sel == REG_TX_DATA);
    assign w_tx_pop   = o_tx_valid & i_tx_ready;
    assign w_tx_flush = w_ctrl_lo & i_wb_dat[C_CTRL_TX_FLUSH];

    assign w_err_clr = (w_wr && w_sel == REG_ERR) ? i_wb_dat[3:0] : 4'b0000;
    assign w_err_set = {w_tx_drop, w_rx_drop,
                        i_rx_valid & i_parity_err, i_rx_valid & i_frame_err};

    assign w_rx_cnt8 = 8'(w_rx_count);
    assign w_tx_cnt8 = 8'(w_tx_count);

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (i_rx_data),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .o_data  (w_rx_head),
        .o_count (w_rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_drop  (w_rx_drop)
    );

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_data  (i_wb_dat[DATA_W-1:0]),
        .i_pop   (w_tx_pop),
        .i_flush (w_tx_flush),
        .o_data  (w_tx_head),
        .o_count (w_tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_drop  (w_tx_drop)
    );

    // Next-state for read data, error flags, control, baud divisor and IRQ
    always_comb begin
        dat_d  = 32'h0;
        err_d  = (err_q & ~w_err_clr) | w_err_set;
        ie_d   = ie_q;
        thr_d  = thr_q;
        baud_d = baud_q;
        irq_d  = (ie_q[C_CTRL_IE_RX_THR] & (thr_q != 8'd0) & (w_rx_cnt8 >= thr_q))
               | (ie_q[C_CTRL_IE_TX_EMPTY] & w_tx_empty)
               | (ie_q[C_CTRL_IE_ERR] & (|err_q));

        if (w_ctrl_lo) ie_d  = i_wb_dat[2:0];
        if (w_ctrl_hi) thr_d = i_wb_dat[15:8];
        if (w_wr && w_sel == REG_BAUD) begin
            if (i_wb_sel[0]) baud_d[7:0]  = i_wb_dat[7:0];
            if (i_wb_sel[1]) baud_d[15:8] = i_wb_dat[15:8];
        end

        if (w_rd) begin
            case (w_sel)
                REG_RX_DATA: dat_d = 32'(w_rx_head);
                REG_STAT: begin
                    dat_d[C_STAT_RX_EMPTY] = w_rx_empty;
                    dat_d[C_STAT_RX_FULL]  = w_rx_full;
                    dat_d[C_STAT_TX_EMPTY] = w_tx_empty;
                    dat_d[C_STAT_TX_FULL]  = w_tx_full;
                    dat_d[C_STAT_ERR_ANY]  = |err_q;
                    dat_d[15:8]            = w_rx_cnt8;
                    dat_d[23:16]           = w_tx_cnt8;
                end
                REG_ERR:  dat_d = {28'h0, err_q};
                REG_CTRL: dat_d = {16'h0, thr_q, 5'b0, ie_q};
                REG_BAUD: dat_d = {16'h0, baud_q};
                default:  dat_d = 32'h0;
            endcase
        end
    end

    // Register state; reset abandons any pending bus cycle without an ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q  <= 1'b0;
            dat_q  <= 32'h0;
            err_q  <= 4'h0;
            ie_q   <= 3'h0;
            thr_q  <= 8'h0;
            baud_q <= BAUD_RST;
            irq_q  <= 1'b0;
        end else begin
            ack_q  <= w_req;
            dat_q  <= dat_d;
            err_q  <= err_d;
            ie_q   <= ie_d;
            thr_q  <= thr_d;
            baud_q <= baud_d;
            irq_q  <= irq_d;
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_dat   = dat_q;
    assign o_tx_data  = w_tx_head;
    assign o_tx_valid = ~w_tx_empty;
    assign o_baud_div = baud_q;
    assign o_irq      = irq_q;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, i_wb_dat[31:16], i_wb_sel[3:2]};

endmodule
`default_nettype wire
